counter_prog: RTL and testbench



---
 rtl/counter_prog_pkg.sv | 8 +
 rtl/counter_prog_if.sv | 18 +
 rtl/counter_prog.sv | 53 +++++
 tb/tb_counter_prog.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/counter_prog_pkg.sv
// counter_prog_pkg: shared state type and direction/mode encodings for counter_prog
package counter_prog_pkg;
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;
endpackage

// File: rtl/counter_prog_if.sv
// counter_prog_if: control/status bundle of counter_prog; COUNTER_PROG_STICKY_EN adds sticky_clr/evt_sticky
interface counter_prog_if #(parameter int WIDTH = 8);
  logic count_en, count_clr, load, dir, mode;
  logic [WIDTH-1:0] load_val, term_val, count;
  logic overflow, underflow, done;
`ifdef COUNTER_PROG_STICKY_EN
  logic sticky_clr, evt_sticky;
  modport master(output count_en, count_clr, load, load_val, dir, mode, term_val, sticky_clr,
                 input count, overflow, underflow, done, evt_sticky);
  modport slave(input count_en, count_clr, load, load_val, dir, mode, term_val, sticky_clr,
                output count, overflow, underflow, done, evt_sticky);
`else
  modport master(output count_en, count_clr, load, load_val, dir, mode, term_val,
                 input count, overflow, underflow, done);
  modport slave(input count_en, count_clr, load, load_val, dir, mode, term_val,
                output count, overflow, underflow, done);
`endif
endinterface

// File: rtl/counter_prog.sv
// counter_prog: up/down counter with programmable terminal, load and wrap/one-shot; COUNTER_PROG_STICKY_EN adds evt_sticky
module counter_prog
  import counter_prog_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TERM_RST = '1
) (
  input logic clk,
  input logic rst,
  counter_prog_if.slave bus
);
  if (WIDTH < 2 || $bits(TERM_RST) != WIDTH) begin : g_bad_width
    $error("counter_prog: WIDTH must be at least 2");
  end
  state_t state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic step, ovf, unf;
  always_comb begin
    step = state == RUN && bus.count_en && !bus.count_clr && !bus.load;
    ovf = step && bus.dir == DIR_UP && count >= bus.term_val;
    unf = step && bus.dir == DIR_DN && count == '0;
    count_nxt = bus.count_clr ? '0 :
                bus.load ? bus.load_val :
                !step ? count :
                bus.mode == MODE_ONESHOT && (ovf || unf) ? count :
                ovf ? '0 :
                unf ? bus.term_val :
                bus.dir == DIR_UP ? count + 1'b1 : count - 1'b1;
    state_nxt = bus.count_clr || bus.load ? RUN :
                bus.mode == MODE_ONESHOT && (ovf || unf) ? HALT : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end
  assign bus.count = count;
  assign bus.overflow = ovf;
  assign bus.underflow = unf;
  assign bus.done = state == HALT;
`ifdef COUNTER_PROG_STICKY_EN
  logic evt_sticky;
  always_ff @(posedge clk) begin
    if (rst || bus.count_clr) evt_sticky <= 1'b0;
    else evt_sticky <= ovf || unf ? 1'b1 : bus.sticky_clr ? 1'b0 : evt_sticky;
  end
  assign bus.evt_sticky = evt_sticky;
`endif
endmodule

// File: tb/tb_counter_prog.sv
// tb_counter_prog: directed plan plus random stimulus against an integer reference model of counter_prog
module tb_counter_prog;
  localparam int W = 8;
  localparam int MASK = (1 << W) - 1;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int m_cnt = 0;
  bit m_run = 1'b1;
  bit m_sticky = 1'b0;
  counter_prog_if #(.WIDTH(W)) bus ();
  counter_prog #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set(bit r, bit c, bit l, bit e, bit d, bit m, int lv, int tv);
    rst = r;
    bus.count_clr = c;
    bus.load = l;
    bus.count_en = e;
    bus.dir = d;
    bus.mode = m;
    bus.load_val = lv[W-1:0];
    bus.term_val = tv[W-1:0];
  endtask
  task automatic cycle();
    bit act, e_ov, e_un;
    #1;
    act = m_run && bus.count_en && !bus.count_clr && !bus.load;
    e_ov = act && bus.dir && m_cnt >= int'(bus.term_val);
    e_un = act && !bus.dir && m_cnt == 0;
    check("overflow", int'(bus.overflow), int'(e_ov));
    check("underflow", int'(bus.underflow), int'(e_un));
    @(posedge clk);
    if (rst || bus.count_clr) begin
      m_cnt = 0;
      m_run = 1'b1;
    end else if (bus.load) begin
      m_cnt = int'(bus.load_val);
      m_run = 1'b1;
    end else if ((e_ov || e_un) && bus.mode) m_run = 1'b0;
    else if (e_ov) m_cnt = 0;
    else if (e_un) m_cnt = int'(bus.term_val);
    else if (act) m_cnt = (m_cnt + (bus.dir ? 1 : -1)) & MASK;
`ifdef COUNTER_PROG_STICKY_EN
    if (rst || bus.count_clr) m_sticky = 1'b0;
    else if (e_ov || e_un) m_sticky = 1'b1;
    else if (bus.sticky_clr) m_sticky = 1'b0;
`endif
    #1;
    check("count", int'(bus.count), m_cnt);
    check("done", int'(bus.done), int'(!m_run));
`ifdef COUNTER_PROG_STICKY_EN
    check("evt_sticky", int'(bus.evt_sticky), int'(m_sticky));
`endif
  endtask
  initial begin
`ifdef COUNTER_PROG_STICKY_EN
    bus.sticky_clr = 1'b0;
`endif
    set(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cycle();
    check("rst_count", int'(bus.count), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_ovf", int'(bus.overflow), 0);
    check("rst_unf", int'(bus.underflow), 0);
    set(0, 0, 0, 1, 1, 0, 0, 'hff);
    repeat (255) cycle();
    check("wrap_top", int'(bus.count), 'hff);
    check("wrap_ovf", int'(bus.overflow), 1);
    cycle();
    check("wrap_zero", int'(bus.count), 0);
    check("wrap_ovf_low", int'(bus.overflow), 0);
    repeat (10) cycle();
    check("wrap_ten", int'(bus.count), 'h0a);
    set(0, 1, 0, 0, 1, 0, 0, 9);
    cycle();
    set(0, 0, 0, 1, 1, 0, 0, 9);
    repeat (9) cycle();
    check("short_top", int'(bus.count), 9);
    check("short_ovf", int'(bus.overflow), 1);
    cycle();
    check("short_zero", int'(bus.count), 0);
    repeat (7) cycle();
    check("short_seven", int'(bus.count), 7);
    bus.term_val = 8'h03;
    cycle();
    check("term_shrink", int'(bus.count), 0);
    set(0, 0, 1, 1, 0, 1, 3, 'hff);
    cycle();
    set(0, 0, 0, 1, 0, 1, 0, 'hff);
    repeat (3) cycle();
    check("os_zero", int'(bus.count), 0);
    check("os_unf", int'(bus.underflow), 1);
    cycle();
    check("os_done", int'(bus.done), 1);
    check("os_unf_low", int'(bus.underflow), 0);
    repeat (5) cycle();
    check("os_hold", int'(bus.count), 0);
    check("os_done_hold", int'(bus.done), 1);
`ifdef COUNTER_PROG_STICKY_EN
    check("sticky_set", int'(bus.evt_sticky), 1);
    bus.sticky_clr = 1'b1;
    cycle();
    check("sticky_clr", int'(bus.evt_sticky), 0);
    bus.sticky_clr = 1'b0;
`endif
    set(0, 0, 1, 1, 1, 0, 'h0a, 'hff);
    cycle();
    set(0, 1, 1, 1, 1, 0, 'h0a, 'hff);
    cycle();
    check("clr_over_load", int'(bus.count), 0);
    set(0, 0, 1, 1, 1, 0, 'h0a, 'hff);
    cycle();
    set(0, 0, 1, 1, 1, 0, 'h55, 'hff);
    cycle();
    check("load_no_step", int'(bus.count), 'h55);
    set(0, 0, 0, 0, 1, 0, 0, 'hff);
    repeat (10) cycle();
    check("en_low_hold", int'(bus.count), 'h55);
    set(0, 0, 1, 1, 0, 1, 1, 'hff);
    cycle();
    set(0, 0, 0, 1, 0, 1, 0, 'hff);
    repeat (2) cycle();
    check("halt_done", int'(bus.done), 1);
    set(1, 0, 0, 1, 0, 1, 0, 'hff);
    cycle();
    check("halt_rst_count", int'(bus.count), 0);
    check("halt_rst_done", int'(bus.done), 0);
    set(0, 0, 0, 1, 1, 0, 0, 'hff);
    cycle();
    check("resume", int'(bus.count), 1);
    set(0, 1, 0, 0, 1, 0, 0, 0);
    cycle();
    set(0, 0, 0, 1, 1, 0, 0, 0);
    repeat (4) cycle();
    check("term0_count", int'(bus.count), 0);
    check("term0_ovf", int'(bus.overflow), 1);
    for (int i = 0; i < 3000; i++) begin
      set($urandom_range(63) == 0, $urandom_range(31) == 0, $urandom_range(15) == 0,
          $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(7) == 0,
          int'($urandom_range(MASK)),
          $urandom_range(1) == 1 ? int'($urandom_range(20)) : int'($urandom_range(MASK)));
`ifdef COUNTER_PROG_STICKY_EN
      bus.sticky_clr = $urandom_range(7) == 0;
`endif
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
